fifo_stream_reader: RTL

//  Read-side drain engine for the synchronous FIFO (fifo_sync). Pops words via rd_en/empty and presents

---
 rtl/fifo_stream_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops a synchronous FIFO and re-times its 1-cycle read latency into a valid/ready stream.
// Optional statistics ports word_cnt/stall_cnt are present only when FIFO_RDR_STATS_EN is defined.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_RDR_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
        $error("fifo_stream_reader: DATA_WIDTH and CNT_WIDTH must be positive");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STOP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            occ;
    logic                  inflight;
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [DATA_WIDTH-1:0] slot [0:2];
    logic [2:0]            level;
    logic                  capture;
    logic                  accept;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pops are limited by buffered plus in-flight words, so the buffer can never overflow
    // and fifo_rd_en stays independent of m_ready.
    always_comb begin
        level      = {1'b0, occ} + {2'b00, inflight};
        fifo_rd_en = (state == ACTIVE) && enable && !flush && !fifo_empty && (level < 3'd3);
        capture    = inflight && !flush;
        accept     = m_valid && m_ready && !flush;
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = slot[rd_ptr];
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (!flush && !enable) state_nxt = STOP;
            end
            STOP: begin
                if (flush)                             state_nxt = IDLE;
                else if (enable)                       state_nxt = ACTIVE;
                else if (occ == 2'd0 && !inflight)     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                slot[i] <= '0;
            end
        end else if (flush) begin
            occ      <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (capture) begin
                slot[wr_ptr] <= fifo_dout;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (accept) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({capture, accept})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_RDR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (m_valid && !m_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_rd_en && fifo_empty));

    a_level_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        level <= 3'd3);

    a_hold_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));

endmodule
